// File: rtl/execute_stage.sv
// execute_stage: operand select/forwarding, ALU/shift/iterative MUL, NZCV flags and execute/memory register.
// Define FORWARDING_EN to enable the own-output/writeback forwarding network.
package execute_stage_pkg;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR, ALU_EOR, ALU_MOV, ALU_LSL, ALU_LSR, ALU_ASR, ALU_MUL
   } alu_op_t;
   typedef enum logic [1:0] {SEL_REG, SEL_IMM, SEL_ACC} sel_t;
   typedef logic [1:0] wb_sel_t;
endpackage

module execute_stage
   import execute_stage_pkg::*;
#(
   parameter int WORD = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int MUL_CYCLES = 32
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   input  logic                  flush_i,
   input  logic                  is_valid_i,
   input  alu_op_t               alu_control_signal_i,
   input  sel_t                  alu_input_1_select_i,
   input  sel_t                  alu_input_2_select_i,
   input  logic                  update_flag_i,
   input  logic                  mem_write_en_i,
   input  logic                  mem_read_en_i,
   input  logic                  reg_file_write_en_i,
   input  wb_sel_t               reg_file_input_ctrl_sig_i,
   input  logic [ADDR_WIDTH-1:0] reg_1_source_addr_i,
   input  logic [ADDR_WIDTH-1:0] reg_2_source_addr_i,
   input  logic [ADDR_WIDTH-1:0] reg_dest_addr_i,
   input  logic [WORD-1:0]       reg_1_data_i,
   input  logic [WORD-1:0]       reg_2_data_i,
   input  logic [WORD-1:0]       immediate_i,
   input  logic [WORD-1:0]       accumulator_imm_i,
   input  logic                  wb_write_en_i,
   input  logic [ADDR_WIDTH-1:0] wb_dest_addr_i,
   input  logic [WORD-1:0]       wb_data_i,
   output logic                  stall_o,
   output logic                  is_valid_o,
   output logic [WORD-1:0]       alu_result_o,
   output logic [WORD-1:0]       store_data_o,
   output logic [ADDR_WIDTH-1:0] reg_dest_addr_o,
   output logic                  mem_write_en_o,
   output logic                  mem_read_en_o,
   output logic                  reg_file_write_en_o,
   output wb_sel_t               reg_file_input_ctrl_sig_o,
   output logic [3:0]            flags_o
);
   localparam logic [0:0] IDLE = 1'b0, BUSY = 1'b1;
   localparam int CW = $clog2(MUL_CYCLES);

   logic [0:0] state;
   logic [CW-1:0] cnt;
   logic [WORD-1:0] acc, mc, mp, partial;
   logic [WORD-1:0] fwd1, fwd2, op1, op2, b, res;
   logic [WORD:0] sum, lsl, lsr;
   logic signed [WORD:0] asr;
   logic [7:0] amt;
   logic is_sub, start, last, accept, c_new, v_new;

`ifdef FORWARDING_EN
   logic own1, own2;
   assign own1 = is_valid_o & reg_file_write_en_o & (reg_dest_addr_o == reg_1_source_addr_i);
   assign own2 = is_valid_o & reg_file_write_en_o & (reg_dest_addr_o == reg_2_source_addr_i);
   assign fwd1 = own1 ? alu_result_o : (wb_write_en_i & (wb_dest_addr_i == reg_1_source_addr_i)) ? wb_data_i : reg_1_data_i;
   assign fwd2 = own2 ? alu_result_o : (wb_write_en_i & (wb_dest_addr_i == reg_2_source_addr_i)) ? wb_data_i : reg_2_data_i;
`else
   logic unused;
   assign unused = ^{wb_write_en_i, wb_dest_addr_i, wb_data_i, reg_1_source_addr_i, reg_2_source_addr_i};
   assign fwd1 = reg_1_data_i;
   assign fwd2 = reg_2_data_i;
`endif

   assign op1 = alu_input_1_select_i == SEL_IMM ? immediate_i :
                alu_input_1_select_i == SEL_ACC ? accumulator_imm_i : fwd1;
   assign op2 = alu_input_2_select_i == SEL_IMM ? immediate_i :
                alu_input_2_select_i == SEL_ACC ? accumulator_imm_i : fwd2;

   assign is_sub = alu_control_signal_i == ALU_SUB;
   assign b = is_sub ? ~op2 : op2;
   assign sum = {1'b0, op1} + {1'b0, b} + {{WORD{1'b0}}, is_sub};
   assign amt = op2[7:0];
   // One extra bit on the out-going side of each shift captures the last bit shifted out.
   assign lsl = {1'b0, op1} << amt;
   assign lsr = {op1, 1'b0} >> amt;
   assign asr = $signed({op1, 1'b0}) >>> amt;
   assign partial = acc + (mp[0] ? mc : '0);

   always_comb begin
      res = '0;
      c_new = flags_o[1];
      v_new = flags_o[0];
      case (alu_control_signal_i)
         ALU_ADD, ALU_SUB: begin
            res = sum[WORD-1:0];
            c_new = sum[WORD];
            v_new = (op1[WORD-1] == b[WORD-1]) & (sum[WORD-1] != op1[WORD-1]);
         end
         ALU_AND: res = op1 & op2;
         ALU_ORR: res = op1 | op2;
         ALU_EOR: res = op1 ^ op2;
         ALU_MOV: res = op2;
         ALU_LSL: begin
            res = lsl[WORD-1:0];
            c_new = amt == 8'd0 ? flags_o[1] : lsl[WORD];
         end
         ALU_LSR: begin
            res = lsr[WORD:1];
            c_new = amt == 8'd0 ? flags_o[1] : lsr[0];
         end
         ALU_ASR: begin
            res = asr[WORD:1];
            c_new = amt == 8'd0 ? flags_o[1] : asr[0];
         end
         ALU_MUL: res = partial;
         default: res = '0;
      endcase
   end

   assign start = (state == IDLE) & is_valid_i & (alu_control_signal_i == ALU_MUL) & ~flush_i;
   assign last = (state == BUSY) & (cnt == CW'(MUL_CYCLES - 1));
   assign stall_o = reset_n_i & (start | ((state == BUSY) & ~last));
   assign accept = is_valid_i & ~stall_o;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state <= IDLE;
         cnt <= '0;
         acc <= '0;
         mc <= '0;
         mp <= '0;
      end else if (start) begin
         state <= BUSY;
         cnt <= '0;
         acc <= '0;
         mc <= op1;
         mp <= op2;
      end else if (state == BUSY) begin
         state <= (flush_i | last) ? IDLE : BUSY;
         cnt <= cnt + CW'(1);
         acc <= partial;
         mc <= mc << 1;
         mp <= mp >> 1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         is_valid_o <= 1'b0;
         alu_result_o <= '0;
         store_data_o <= '0;
         reg_dest_addr_o <= '0;
         mem_write_en_o <= 1'b0;
         mem_read_en_o <= 1'b0;
         reg_file_write_en_o <= 1'b0;
         reg_file_input_ctrl_sig_o <= '0;
         flags_o <= '0;
      end else begin
         is_valid_o <= accept & ~flush_i;
         if (accept) begin
            alu_result_o <= res;
            store_data_o <= fwd2;
            reg_dest_addr_o <= reg_dest_addr_i;
            mem_write_en_o <= mem_write_en_i;
            mem_read_en_o <= mem_read_en_i;
            reg_file_write_en_o <= reg_file_write_en_i;
            reg_file_input_ctrl_sig_o <= reg_file_input_ctrl_sig_i;
         end
         if (accept & ~flush_i & update_flag_i)
            flags_o <= {res[WORD-1], res == '0, c_new, v_new};
      end
   end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed-vector bench for execute_stage; expectations follow FORWARDING_EN.
module tb_execute_stage;
   import execute_stage_pkg::*;

   logic clk = 1'b0, rst_n, flush, vin, uf, mwe, mre, rwe, wbwe;
   alu_op_t op;
   sel_t s1, s2;
   wb_sel_t rctl;
   logic [3:0] ra, rb, rd, wbd, rd_o;
   logic [31:0] da, db, imm, acc, wbdata;
   logic stall, vout, mwe_o, mre_o, rwe_o;
   logic [31:0] res_o, st_o;
   wb_sel_t rctl_o;
   logic [3:0] flags;
   int total = 0, bad = 0;

   execute_stage dut (
      .clk_i(clk), .reset_n_i(rst_n), .flush_i(flush), .is_valid_i(vin),
      .alu_control_signal_i(op), .alu_input_1_select_i(s1), .alu_input_2_select_i(s2),
      .update_flag_i(uf), .mem_write_en_i(mwe), .mem_read_en_i(mre),
      .reg_file_write_en_i(rwe), .reg_file_input_ctrl_sig_i(rctl),
      .reg_1_source_addr_i(ra), .reg_2_source_addr_i(rb), .reg_dest_addr_i(rd),
      .reg_1_data_i(da), .reg_2_data_i(db), .immediate_i(imm), .accumulator_imm_i(acc),
      .wb_write_en_i(wbwe), .wb_dest_addr_i(wbd), .wb_data_i(wbdata),
      .stall_o(stall), .is_valid_o(vout), .alu_result_o(res_o), .store_data_o(st_o),
      .reg_dest_addr_o(rd_o), .mem_write_en_o(mwe_o), .mem_read_en_o(mre_o),
      .reg_file_write_en_o(rwe_o), .reg_file_input_ctrl_sig_o(rctl_o), .flags_o(flags)
   );

   always #5 clk = ~clk;

   task automatic drive(input alu_op_t o, input sel_t a, input sel_t b, input logic [3:0] xa, xb, xd,
                        input logic [31:0] xda, xdb, xim, xac, input logic xuf);
      vin = 1'b1; op = o; s1 = a; s2 = b; ra = xa; rb = xb; rd = xd;
      da = xda; db = xdb; imm = xim; acc = xac; uf = xuf; rwe = 1'b1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; flush = 1'b0; vin = 1'b0; uf = 1'b0; mwe = 1'b0; mre = 1'b0; rwe = 1'b0;
      wbwe = 1'b0; op = ALU_ADD; s1 = SEL_REG; s2 = SEL_REG; rctl = 2'd0;
      ra = 0; rb = 0; rd = 0; wbd = 0; da = 0; db = 0; imm = 0; acc = 0; wbdata = 0;
      #12;
      total++; if (vout !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", vout); end
      total++; if (res_o !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", res_o); end
      total++; if (flags !== 4'h0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", flags); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_add_sub;
      drive(ALU_ADD, SEL_REG, SEL_IMM, 4'd1, 4'd2, 4'd9, 32'h7FFFFFFF, 32'h0, 32'h1, 32'h0, 1'b1);
      tick();
      total++; if (vout !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", vout); end
      total++; if (res_o !== 32'h80000000) begin bad++; $display("FAIL add_result got=%h exp=80000000", res_o); end
      total++; if (flags !== 4'b1001) begin bad++; $display("FAIL add_flags got=%b exp=1001", flags); end
      total++; if (rd_o !== 4'd9) begin bad++; $display("FAIL add_dest got=%0d exp=9", rd_o); end
      drive(ALU_SUB, SEL_REG, SEL_REG, 4'd1, 4'd2, 4'd9, 32'd5, 32'd5, 32'h0, 32'h0, 1'b1);
      tick();
      total++; if (res_o !== 32'h0) begin bad++; $display("FAIL sub_result got=%h exp=0", res_o); end
      total++; if (flags !== 4'b0110) begin bad++; $display("FAIL sub_flags got=%b exp=0110", flags); end
   endtask

   task automatic test_logic;
      alu_op_t lo [4] = '{ALU_AND, ALU_EOR, ALU_MOV, ALU_ORR};
      logic [31:0] la [4] = '{32'hF0F0, 32'hFFFFFFFF, 32'h1234, 32'h1234};
      logic [31:0] lb [4] = '{32'hFF00, 32'h0, 32'h0, 32'h0};
      logic [31:0] lr [4] = '{32'hF000, 32'hFFFFFFFF, 32'h0, 32'h1234};
      logic [3:0] lf [4] = '{4'b0010, 4'b1010, 4'b0110, 4'b0010};
      for (int i = 0; i < 4; i++) begin
         drive(lo[i], SEL_REG, SEL_IMM, 4'd1, 4'd2, 4'd9, la[i], 32'h0, lb[i], 32'h0, 1'b1);
         tick();
         total++; if (res_o !== lr[i]) begin bad++; $display("FAIL logic%0d_result got=%h exp=%h", i, res_o, lr[i]); end
         total++; if (flags !== lf[i]) begin bad++; $display("FAIL logic%0d_flags got=%b exp=%b", i, flags, lf[i]); end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] e_eor, e_orr;
`ifdef FORWARDING_EN
      e_eor = 32'hC; e_orr = 32'h50;
`else
      e_eor = 32'h10F; e_orr = 32'h100;
`endif
      drive(ALU_ADD, SEL_REG, SEL_REG, 4'd1, 4'd2, 4'd3, 32'd1, 32'd2, 32'h0, 32'h0, 1'b0);
      tick();
      total++; if (res_o !== 32'd3) begin bad++; $display("FAIL b2b_add got=%h exp=3", res_o); end
      drive(ALU_EOR, SEL_REG, SEL_IMM, 4'd3, 4'd0, 4'd4, 32'h100, 32'h0, 32'hF, 32'h0, 1'b0);
      wbwe = 1'b1; wbd = 4'd3; wbdata = 32'h50;
      tick();
      total++; if (res_o !== e_eor) begin bad++; $display("FAIL b2b_eor got=%h exp=%h", res_o, e_eor); end
      drive(ALU_ORR, SEL_REG, SEL_IMM, 4'd3, 4'd0, 4'd5, 32'h100, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      total++; if (res_o !== e_orr) begin bad++; $display("FAIL b2b_wb got=%h exp=%h", res_o, e_orr); end
      wbwe = 1'b0;
   endtask

   task automatic test_shift;
      alu_op_t so [7] = '{ALU_LSL, ALU_LSL, ALU_LSL, ALU_LSR, ALU_LSR, ALU_ASR, ALU_ASR};
      logic [31:0] sa [7] = '{32'h80000001, 32'h80000001, 32'h80000001, 32'h80000001,
                              32'h80000001, 32'h80000000, 32'h80000000};
      logic [31:0] sn [7] = '{32'd1, 32'd32, 32'd40, 32'd0, 32'd32, 32'd40, 32'd4};
      logic [31:0] sr [7] = '{32'h2, 32'h0, 32'h0, 32'h80000001, 32'h0, 32'hFFFFFFFF, 32'hF8000000};
      logic [3:0] sf [7] = '{4'b0010, 4'b0110, 4'b0100, 4'b1000, 4'b0110, 4'b1010, 4'b1000};
      for (int i = 0; i < 7; i++) begin
         drive(so[i], SEL_REG, SEL_IMM, 4'd1, 4'd2, 4'd9, sa[i], 32'h0, sn[i], 32'h0, 1'b1);
         tick();
         total++; if (res_o !== sr[i]) begin bad++; $display("FAIL shift%0d_result got=%h exp=%h", i, res_o, sr[i]); end
         total++; if (flags !== sf[i]) begin bad++; $display("FAIL shift%0d_flags got=%b exp=%b", i, flags, sf[i]); end
      end
   endtask

   task automatic test_mul;
      int n;
      drive(ALU_ADD, SEL_IMM, SEL_ACC, 4'd0, 4'd0, 4'd9, 32'h0, 32'h0, 32'h80000000, 32'h80000000, 1'b1);
      tick();
      total++; if (flags !== 4'b0111) begin bad++; $display("FAIL mul_pre_flags got=%b exp=0111", flags); end
      drive(ALU_MUL, SEL_IMM, SEL_ACC, 4'd0, 4'd0, 4'd7, 32'h0, 32'h0, 32'h10000, 32'h10001, 1'b1);
      #1;
      n = 0;
      while (stall && n < 100) begin n++; tick(); end
      total++; if (n !== 32) begin bad++; $display("FAIL mul_stall_cycles got=%0d exp=32", n); end
      tick();
      vin = 1'b0;
      total++; if (vout !== 1'b1) begin bad++; $display("FAIL mul_valid got=%b exp=1", vout); end
      total++; if (res_o !== 32'h00010000) begin bad++; $display("FAIL mul_result got=%h exp=00010000", res_o); end
      total++; if (flags !== 4'b0011) begin bad++; $display("FAIL mul_flags got=%b exp=0011", flags); end
      total++; if (rd_o !== 4'd7) begin bad++; $display("FAIL mul_dest got=%0d exp=7", rd_o); end
   endtask

   task automatic test_flush;
      logic seen;
      drive(ALU_ADD, SEL_IMM, SEL_ACC, 4'd0, 4'd0, 4'd9, 32'h0, 32'h0, 32'h1, 32'hFFFFFFFF, 1'b1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      total++; if (vout !== 1'b0) begin bad++; $display("FAIL flush_alu_valid got=%b exp=0", vout); end
      total++; if (flags !== 4'b0011) begin bad++; $display("FAIL flush_alu_flags got=%b exp=0011", flags); end
      drive(ALU_MUL, SEL_IMM, SEL_ACC, 4'd0, 4'd0, 4'd7, 32'h0, 32'h0, 32'h80000000, 32'h1, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL flush_busy_stall got=%b exp=1", stall); end
      flush = 1'b1;
      tick();
      flush = 1'b0; vin = 1'b0;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall_drop got=%b exp=0", stall); end
      seen = 1'b0;
      repeat (40) begin tick(); if (vout) seen = 1'b1; end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_mul_valid got=%b exp=0", seen); end
      total++; if (flags !== 4'b0011) begin bad++; $display("FAIL flush_mul_flags got=%b exp=0011", flags); end
   endtask

   task automatic test_reset_mid_mul;
      drive(ALU_ADD, SEL_IMM, SEL_ACC, 4'd0, 4'd0, 4'd6, 32'h0, 32'h0, 32'h1, 32'h1, 1'b0);
      tick();
      total++; if (res_o !== 32'h2) begin bad++; $display("FAIL rst_pre_result got=%h exp=2", res_o); end
      drive(ALU_MUL, SEL_IMM, SEL_ACC, 4'd0, 4'd0, 4'd7, 32'h0, 32'h0, 32'h3, 32'h5, 1'b1);
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_mul_stall got=%b exp=0", stall); end
      total++; if (vout !== 1'b0) begin bad++; $display("FAIL rst_mul_valid got=%b exp=0", vout); end
      total++; if (res_o !== 32'h0) begin bad++; $display("FAIL rst_mul_result got=%h exp=0", res_o); end
      total++; if (flags !== 4'h0) begin bad++; $display("FAIL rst_mul_flags got=%b exp=0000", flags); end
      total++; if (rd_o !== 4'd0) begin bad++; $display("FAIL rst_mul_dest got=%0d exp=0", rd_o); end
      vin = 1'b0;
      #10;
      rst_n = 1'b1;
      tick();
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_release_stall got=%b exp=0", stall); end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_logic();
      test_back_to_back();
      test_shift();
      test_mul();
      test_flush();
      test_reset_mid_mul();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Sits directly downstream of the decode/execution pipeline register and consumes everything it registers.
- Selects ALU operands: register, immediate or accumulator immediate, with forwarding.
- Executes ALU, shift and iterative-multiply ops, and maintains the NZCV flag register.
- Drives a registered result bundle (the execute/memory boundary) toward the memory stage, and stalls upstream during multi-cycle multiplies.

Parameters:
- WORD, 32, datapath width.
- ADDR_WIDTH, 4, register address width.
- MUL_CYCLES, 32, cycles an iterative multiply occupies (one multiplier bit per cycle; must equal WORD).

Ports:
- clk_i  in  1  clock, all state on rising edge.
- reset_n_i  in  1  reset, asynchronous assert, active-low.
- flush_i  in  1  kill instruction in this stage (branch mispredict).
- is_valid_i  in  1  instruction valid from decode/execution register.
- alu_control_signal_i, alu_input_1_select_i, alu_input_2_select_i, update_flag_i  in  pkg types  operation and operand selects.
- mem_write_en_i, mem_read_en_i, reg_file_write_en_i, reg_file_input_ctrl_sig_i  in  pkg types  passed through to outputs.
- reg_1_source_addr_i, reg_2_source_addr_i, reg_dest_addr_i  in  ADDR_WIDTH  source and destination addresses.
- reg_1_data_i, reg_2_data_i  in  WORD  register-file read data.
- immediate_i, accumulator_imm_i  in  WORD  immediate operands.
- wb_write_en_i  in  1  writeback stage writing.
- wb_dest_addr_i  in  ADDR_WIDTH  writeback destination.
- wb_data_i  in  WORD  writeback data.
- stall_o  out  1  hold decode/execution register and upstream.
- is_valid_o  out  1  result bundle valid.
- alu_result_o  out  WORD  registered result.
- store_data_o  out  WORD  forwarded reg-2 value, used as store data.
- reg_dest_addr_o  out  ADDR_WIDTH  registered destination.
- mem_write_en_o, mem_read_en_o, reg_file_write_en_o, reg_file_input_ctrl_sig_o  out  pkg types  registered pass-through.
- flags_o  out  4  NZCV register, {N,Z,C,V}.

Behaviour:
- Reset: one clock; asynchronous active-low reset on reset_n_i. While reset_n_i=0:
  - every output register, flags_o and the multiplier state clear to 0;
  - FSM returns to IDLE;
  - stall_o=0.
- Operand select (per alu_input_N_select): REG → forwarded register value; IMM → immediate_i; ACC → accumulator_imm_i.
- Forwarding priority, per source, highest first:
  1. own output register (is_valid_o & reg_file_write_en_o & reg_dest_addr_o==src addr);
  2. writeback (wb_write_en_i & wb_dest_addr_i==src addr);
  3. reg_N_data_i.
- Single-cycle ops (ADD, SUB, AND, ORR, EOR, MOV, LSL, LSR, ASR):
  - Latency 1: result, pass-through controls and is_valid_o appear the cycle after acceptance.
  - An instruction is accepted when is_valid_i=1 and stall_o=0.
- Arithmetic: 32-bit wrap.
  - ADD: C = carry out; V = signed overflow.
  - SUB: op1+~op2+1; C = NOT borrow.
- Shifts: amount = op2[7:0].
  - 0 → result=op1, C unchanged.
  - 1..31 → normal shift; C = last bit shifted out.
  - ≥32 → LSL/LSR give 0; ASR gives 32 copies of op1[31].
  - C for amount=32: LSL op1[0], LSR op1[31]. C for amount >32: LSL/LSR 0. ASR C = op1[31] for any amount ≥32.
- Flags: written only when the instruction is accepted, not flushed, and update_flag_i asserted.
  - N=result[31]; Z=(result==0).
  - Logical ops and MOV leave C,V unchanged.
  - MUL updates N,Z only.
- MUL FSM, states IDLE, BUSY:
  - IDLE → BUSY when a valid MUL is presented; operands are latched; stall_o=1 combinationally from that cycle.
  - BUSY: shift-add one bit per cycle; counter counts 0..MUL_CYCLES-1; stall_o=1 until the final count.
  - Final count: stall_o=0, the instruction is accepted, and the low WORD bits of the product are registered next edge.
  - Total occupancy is MUL_CYCLES+1 cycles.
- Flush:
  - Accepted instruction: flush_i=1 forces is_valid_o=0 next cycle and suppresses the flag write.
  - During BUSY: flush_i returns the FSM to IDLE and drops stall_o the next cycle; no result and no flag write.
- When not accepting and not flushed, is_valid_o=0 next cycle. Data outputs may hold any value when is_valid_o=0.

Optional Feature:
- FORWARDING_EN defined: forwarding network as above.
- FORWARDING_EN undefined: REG operands come from reg_N_data_i directly. The compiler/hazard unit must insert bubbles; wb_* inputs are ignored.

Test Plan:
- ADD reg1=0x7FFFFFFF, imm=1, update_flag=1 → alu_result_o=0x80000000 one cycle later, flags_o=4'b1001 (N,V).
- SUB r1=r2=5 with flags → result 0, flags_o=4'b0110 (Z,C).
- Back-to-back: ADD r3=r1+r2 (1+2) then EOR r4=r3^imm 0xF → second result 0xC via own-output forwarding. Repeat with FORWARDING_EN undefined → stale reg_1_data_i value used.
- LSL op1=0x80000001, shift amounts 1, 32 and 40 → results 0x00000002 (C=1), 0 (C=1), 0 (C=0).
- MUL 0x10000 × 0x10001 → stall_o high for 32 cycles, result 0x00010000, N=0 Z=0, C,V unchanged.
- Flush in BUSY cycle 10 → stall_o low next cycle, no is_valid_o pulse, flags unchanged. Also: reset_n_i low mid-MUL → all outputs 0 immediately.
